spart_rx_deser: RTL and testbench
=================================

SPART_RX_DESER -- requirements
Module: spart_rx_deser

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets the number of baud ticks per bit period.
REQ-002 Parameter SYNC_STAGES, default 2, sets the depth of the rxd synchronizer flops.
REQ-003 Port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port rxd, input, 1 bit: asynchronous serial line from the workstation; idles high.
REQ-006 Port divisor_buffer, input, 16 bits: baud divisor from the SPART bus interface.
REQ-007 Port rx_shift_reg, output, 10 bits: last completed frame as {stop, data[7:0], start}.
REQ-008 Port rx_done, output, 1 bit: one-cycle pulse marking that rx_shift_reg has been updated.
REQ-009 Port framing_err, output, 1 bit: stop bit of the last completed frame sampled as 0.
REQ-010 Port rx_busy, output, 1 bit: high while the FSM is in any state other than IDLE.

Function
REQ-011 rxd SHALL pass through SYNC_STAGES flops that reset to 1; the FSM uses only the synchronized value, rxd_s.
REQ-012 The baud tick SHALL fire once every divisor_buffer+1 clocks; divisor 0 gives a tick every clock.
REQ-013 The baud counter SHALL free-run, reloading divisor_buffer when it reaches 0; a divisor change takes effect at the next reload.
REQ-014 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 The sample counter SHALL be 4 bits, counting baud ticks within a bit and wrapping 15->0.
REQ-016 IDLE: when armed and rxd_s==0, go to START and clear the sample counter.
REQ-017 START: on the tick where the sample count is 7 (mid-bit), rxd_s==1 means a false start, so return to IDLE with no rx_done.
REQ-018 START: on that same tick, rxd_s==0 means shift in the start bit, clear the sample and bit counters, and go to DATA.
REQ-019 DATA: every 16th tick after the previous sample, shift in rxd_s LSB-first; after 8 bits go to STOP.
REQ-020 Shifting SHALL be right-shift into bit 9 of an internal 10-bit register, so the start bit ends in bit 0 and data LSB in bit 1.
REQ-021 STOP: on the 16th tick, shift in the stop bit, then on the next clock load rx_shift_reg, pulse rx_done for exactly 1 cycle, set framing_err=~stop, and go to IDLE.
REQ-022 rx_shift_reg and framing_err SHALL hold their values until the next rx_done; they never change mid-frame.
REQ-023 After a frame with framing_err=1, IDLE SHALL disarm until rxd_s==1 is seen, so a line break yields exactly one frame.
REQ-024 Because the stop bit is sampled at mid-bit, a start edge arriving half a bit later SHALL be accepted (back-to-back frames).
REQ-025 rx_busy SHALL be combinational from state, and is 0 only in IDLE.

Reset
REQ-026 On rst low: state IDLE, armed=1, synchronizer=1, all counters 0, internal shift register 0.
REQ-027 On rst low: rx_shift_reg=0, rx_done=0, framing_err=0.
REQ-028 Reset mid-frame SHALL discard the partial frame and produce no rx_done after release.
REQ-029 After release the block SHALL wait for a fresh falling edge on rxd_s.

Structure
REQ-030 Package spart_pkg SHALL hold the rx_state_t enum and constants DATA_BITS=8, MID_SAMPLE=7 and FRAME_BITS=10.
REQ-031 Baud tick generation SHALL be a sub-module named spart_baud_gen (clk, rst, divisor_buffer -> tick), reused by the transmit side.

Verification
REQ-032 divisor=0, frame 0x55 (16 clk/bit): rx_shift_reg=10'h2AA, one-cycle rx_done, framing_err=0.
REQ-033 divisor=0, rxd low for 4 clks then high: no rx_done, and rx_busy returns to 0 within 8 clks.
REQ-034 divisor=0, data 0x00 with stop bit 0, line held low 400 clks: one rx_done, rx_shift_reg=10'h000, framing_err=1; the next frame 0x3C, sent after rxd goes high, gives 10'h278.
REQ-035 divisor=3, back-to-back frames 0xA5 and 0x3C: rx_shift_reg=10'h34A then 10'h278, rx_done 640 clks apart, framing_err=0.
REQ-036 rst asserted during bit 4 of frame 0xFF, then a clean 0x81 sent: exactly one rx_done with rx_shift_reg=10'h302.
REQ-037 divisor changed from 0 to 1 mid-idle: the bit period measures 32 clks starting with the next frame.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial blocks.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 7;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spart_baud_gen.sv
// Free-running baud tick generator: one tick every divisor_buffer+1 clocks.
// A new divisor is picked up only when the counter reloads.
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor_buffer,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  // Count down and reload from the divisor when the count hits zero.
  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (cnt_q == 16'd0) begin
      cnt_d = divisor_buffer;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 16'd0);

endmodule

// File: rtl/spart_rx_deser.sv
// SPART receive deserializer: synchronizes rxd, finds the start bit at
// mid-bit, shifts in 8 data bits LSB-first plus the stop bit, and publishes
// the completed frame with a one-cycle rx_done pulse.
module spart_rx_deser
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           divisor_buffer,
  output logic [FRAME_BITS-1:0] rx_shift_reg,
  output logic                  rx_done,
  output logic                  framing_err,
  output logic                  rx_busy
);

  localparam logic [3:0] SAMP_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic                   tick;
  logic                   rxd_s;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  rx_state_t              state_q, state_d;
  logic [3:0]             samp_q, samp_d;
  logic [2:0]             bit_q, bit_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic                   armed_q, armed_d;
  logic                   pend_q, pend_d;
  logic [FRAME_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;

  spart_baud_gen u_baud (
    .clk            (clk),
    .rst            (rst),
    .divisor_buffer (divisor_buffer),
    .tick           (tick)
  );

  // Synchronizer chain: rxd enters at stage 0, rxd_s leaves the last stage.
  always_comb begin
    sync_d[0] = rxd;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Synchronizer flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Next-state logic: frame detection, mid-bit sampling and frame publish.
  // pend_q marks that the stop bit is in shreg_q; the publish happens one
  // clock later so rx_shift_reg only changes together with rx_done.
  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    armed_d    = armed_q;
    pend_d     = pend_q;
    rx_shift_d = rx_shift_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;

    unique case (state_q)
      IDLE: begin
        if (!armed_q) begin
          // After a framing error wait for the line to recover first.
          if (rxd_s) begin
            armed_d = 1'b1;
          end
        end else if (!rxd_s) begin
          state_d = START;
          samp_d  = 4'd0;
        end
      end

      START: begin
        if (tick) begin
          if (samp_q == SAMP_MID) begin
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              shreg_d = {rxd_s, shreg_q[FRAME_BITS-1:1]};
              samp_d  = 4'd0;
              bit_d   = 3'd0;
              state_d = DATA;
            end
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == SAMP_LAST) begin
            shreg_d = {rxd_s, shreg_q[FRAME_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = 3'd0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end

      STOP: begin
        if (pend_q) begin
          rx_shift_d = shreg_q;
          done_d     = 1'b1;
          ferr_d     = ~shreg_q[FRAME_BITS-1];
          armed_d    = shreg_q[FRAME_BITS-1];
          pend_d     = 1'b0;
          state_d    = IDLE;
        end else if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == SAMP_LAST) begin
            shreg_d = {rxd_s, shreg_q[FRAME_BITS-1:1]};
            pend_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shift register and published outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      samp_q     <= 4'd0;
      bit_q      <= 3'd0;
      shreg_q    <= '0;
      armed_q    <= 1'b1;
      pend_q     <= 1'b0;
      rx_shift_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      armed_q    <= armed_d;
      pend_q     <= pend_d;
      rx_shift_q <= rx_shift_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_shift_reg = rx_shift_q;
  assign rx_done      = done_q;
  assign framing_err  = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spart_rx_deser.sv
// Self-checking bench for spart_rx_deser: directed frames plus randomized
// frames, compared against a frame-level reference model.
module tb_spart_rx_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] divisor_buffer = 16'd0;
  logic [9:0]  rx_shift_reg;
  logic        rx_done;
  logic        framing_err;
  logic        rx_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  spart_rx_deser #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rxd            (rxd),
    .divisor_buffer (divisor_buffer),
    .rx_shift_reg   (rx_shift_reg),
    .rx_done        (rx_done),
    .framing_err    (framing_err),
    .rx_busy        (rx_busy)
  );

  // Reference model: a UART frame is {stop, data, start=0}; error = ~stop.
  logic [9:0] exp_frame[$];
  logic       exp_ferr[$];

  // Observed completed frames.
  logic [9:0] got_frame[$];
  logic       got_ferr[$];
  int         got_cyc[$];

  logic [9:0] last_sr    = 10'd0;
  logic       last_fe    = 1'b0;
  logic       prev_done  = 1'b0;
  int         hold_viol  = 0;
  int         width_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log rx_done events, watch pulse width and output stability.
  always @(negedge clk) begin
    if (!rst) begin
      last_sr   <= rx_shift_reg;
      last_fe   <= framing_err;
      prev_done <= 1'b0;
    end else begin
      if (rx_done) begin
        got_frame.push_back(rx_shift_reg);
        got_ferr.push_back(framing_err);
        got_cyc.push_back(cyc);
        if (prev_done) width_viol <= width_viol + 1;
      end else if (rx_shift_reg !== last_sr || framing_err !== last_fe) begin
        hold_viol <= hold_viol + 1;
      end
      last_sr   <= rx_shift_reg;
      last_fe   <= framing_err;
      prev_done <= rx_done;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] d, input logic stop);
    exp_frame.push_back({stop, d, 1'b0});
    exp_ferr.push_back(~stop);
  endfunction

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; rst_bit >= 0 pulses reset in the middle of that bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk, input int rst_bit);
    logic bv;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      bv = 1'b0;
      else if (b == 9) bv = stop;
      else             bv = d[b-1];
      rxd = bv;
      for (int k = 0; k < bclk; k++) begin
        @(negedge clk);
        if (b == rst_bit && k == bclk / 2) rst = 1'b0;
        if (b == rst_bit && k == bclk / 2 + 1) begin
          check_val("midrst_shift_reg", 32'(rx_shift_reg), 32'h0);
          check_val("midrst_done", 32'(rx_done), 32'h0);
          check_val("midrst_ferr", 32'(framing_err), 32'h0);
          check_val("midrst_busy", 32'(rx_busy), 32'h0);
        end
        if (b == rst_bit && k == bclk / 2 + 3) rst = 1'b1;
      end
    end
  endtask

  task automatic check_frames(input string tag);
    int n;
    repeat (8) @(negedge clk);
    check_val({tag, "_count"}, 32'(got_frame.size()), 32'(exp_frame.size()));
    n = (got_frame.size() < exp_frame.size()) ? got_frame.size() : exp_frame.size();
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_frame"}, 32'(got_frame[i]), 32'(exp_frame[i]));
      check_val({tag, "_ferr"}, 32'(got_ferr[i]), 32'(exp_ferr[i]));
    end
    exp_frame.delete();
    exp_ferr.delete();
    got_frame.delete();
    got_ferr.delete();
    got_cyc.delete();
  endtask

  initial begin
    int  gap;
    bit  seen_idle;
    logic [7:0] d;
    logic stop;
    int  bclk;

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("rst_shift_reg", 32'(rx_shift_reg), 32'h0);
    check_val("rst_done", 32'(rx_done), 32'h0);
    check_val("rst_ferr", 32'(framing_err), 32'h0);
    check_val("rst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b1;
    idle(20);

    // Frame 0x55 at 16 clocks per bit.
    model_push(8'h55, 1'b1);
    send_frame(8'h55, 1'b1, 16, -1);
    idle(20);
    check_val("f55_ferr_out", 32'(framing_err), 32'h0);
    check_frames("f55");

    // Short glitch: false start, no frame.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check_val("glitch_busy_high", 32'(rx_busy), 32'h1);
    rxd = 1'b1;
    seen_idle = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!rx_busy) seen_idle = 1'b1;
    end
    check_val("glitch_busy_low", 32'(seen_idle), 32'h1);
    idle(30);
    check_frames("glitch");

    // Line break: one framing-error frame, then a clean 0x3C.
    model_push(8'h00, 1'b0);
    rxd = 1'b0;
    repeat (400) @(negedge clk);
    idle(40);
    check_val("break_ferr_out", 32'(framing_err), 32'h1);
    model_push(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, 16, -1);
    idle(20);
    check_frames("break");

    // Divisor 3: back-to-back 0xA5, 0x3C.
    divisor_buffer = 16'd3;
    idle(20);
    model_push(8'hA5, 1'b1);
    model_push(8'h3C, 1'b1);
    send_frame(8'hA5, 1'b1, 64, -1);
    send_frame(8'h3C, 1'b1, 64, -1);
    idle(40);
    gap = (got_cyc.size() >= 2) ? (got_cyc[1] - got_cyc[0]) : -1;
    check_val("div3_gap", 32'(gap), 32'd640);
    check_frames("div3");

    // Divisor 0 -> 1 while idle: 32 clocks per bit from the next frame.
    divisor_buffer = 16'd0;
    idle(20);
    divisor_buffer = 16'd1;
    idle(20);
    model_push(8'h5A, 1'b1);
    model_push(8'hC3, 1'b1);
    send_frame(8'h5A, 1'b1, 32, -1);
    send_frame(8'hC3, 1'b1, 32, -1);
    idle(20);
    gap = (got_cyc.size() >= 2) ? (got_cyc[1] - got_cyc[0]) : -1;
    check_val("div1_gap", 32'(gap), 32'd320);
    check_frames("div1");

    // Reset during bit 4 of 0xFF, then a clean 0x81.
    divisor_buffer = 16'd0;
    idle(20);
    send_frame(8'hFF, 1'b1, 16, 4);
    idle(30);
    model_push(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, 16, -1);
    idle(20);
    check_frames("midrst");

    // Randomized frames with random divisors, gaps and stop bits.
    for (int f = 0; f < 30; f++) begin
      if (f % 5 == 0) begin
        divisor_buffer = 16'($urandom_range(0, 3));
        idle(10);
      end
      bclk = 16 * (int'(divisor_buffer) + 1);
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      model_push(d, stop);
      send_frame(d, stop, bclk, -1);
      if (!stop) idle(bclk + $urandom_range(0, 20));
      else       idle($urandom_range(0, 2 * bclk));
    end
    idle(40);
    check_frames("rand");

    check_val("done_width", 32'(width_viol), 32'h0);
    check_val("hold_outputs", 32'(hold_viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
